// File: rtl/mips_cpu_muldiv_pkg.sv
// mips_cpu_muldiv_pkg: shared op/state encodings and the magnitude helper for the mul/div unit
package mips_cpu_muldiv_pkg;
  localparam int MAXW = 128;
  typedef enum logic [2:0] {
    NOP   = 3'd0,
    MULT  = 3'd1,
    MULTU = 3'd2,
    DIV   = 3'd3,
    DIVU  = 3'd4,
    MTHI  = 3'd5,
    MTLO  = 3'd6
  } md_op_t;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  // Two's-complement negate when neg is set; callers zero-extend in and truncate out,
  // so the same helper serves every width up to MAXW.
  function automatic logic [MAXW-1:0] abs_val(input logic [MAXW-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction
endpackage

// File: rtl/mips_cpu_muldiv_core.sv
// mips_cpu_muldiv_core: unsigned radix-2 shift-add multiply / restoring divide datapath
// Ports: clk; load captures a (into the low half) and b; step runs one iteration
// (multiply when is_div=0, divide when is_div=1); acc_hi/acc_lo are the accumulator halves.
module mips_cpu_muldiv_core #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_hi,
  output logic [WIDTH-1:0] acc_lo
);
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0] m;
  logic [WIDTH:0] sum, diff;
  always_comb begin
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
    // trial subtract against the remainder as it will be after the left shift
    diff   = acc[2*WIDTH-1:WIDTH-1] - {1'b0, m};
    acc_hi = acc[2*WIDTH-1:WIDTH];
    acc_lo = acc[WIDTH-1:0];
  end
  always_ff @(posedge clk)
    if (load) begin
      acc <= {{WIDTH{1'b0}}, a};
      m   <= b;
    end else if (step) begin
      acc <= !is_div ? {sum, acc[WIDTH-1:1]} :
             diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} :
             {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
endmodule

// File: rtl/mips_cpu_muldiv.sv
// mips_cpu_muldiv: multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with HI/LO registers
// Ports: clk, reset (sync, active high); start/op/a/b issue an operation while busy=0;
// busy while iterating; done pulses for one cycle with new hi/lo; div_zero is sticky until the next start.
module mips_cpu_muldiv
  import mips_cpu_muldiv_pkg::*;
#(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic is_div, neg_q, neg_r, dz;
  logic accept, is_mul, is_dv, sa, sb, load, step, b_zero;
  logic [WIDTH-1:0] ma, mb, acc_hi, acc_lo, res_hi, res_lo;
  logic [2*WIDTH-1:0] prod;
  always_comb begin
    accept = start && state == IDLE;
    is_mul = op == MULT || op == MULTU;
    is_dv  = op == DIV || op == DIVU;
    sa     = (op == MULT || op == DIV) && a[WIDTH-1];
    sb     = (op == MULT || op == DIV) && b[WIDTH-1];
    b_zero = b == '0;
    ma     = WIDTH'(abs_val(MAXW'(a), sa));
    mb     = WIDTH'(abs_val(MAXW'(b), sb));
  end
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  always_comb
    state_nx = state == IDLE ? (load ? (is_dv && b_zero ? FIX : CALC) : IDLE) :
               state == CALC ? (cnt == '0 ? FIX : CALC) : IDLE;
  always_comb begin
    busy = state != IDLE;
    load = accept && (is_mul || is_dv);
    step = state == CALC;
  end
  mips_cpu_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .load   (load),
    .step   (step),
    .is_div (is_div),
    .a      (ma),
    .b      (mb),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo)
  );
  always_ff @(posedge clk)
    if (load) begin
      is_div <= is_dv;
      neg_q  <= sa ^ sb;
      neg_r  <= sa;
      dz     <= is_dv && b_zero;
      cnt    <= CW'(WIDTH - 1);
    end else if (step) begin
      cnt <= cnt - CW'(1);
    end
  // On divide-by-zero the core still holds |a|; re-applying a's sign restores a for HI.
  always_comb begin
    prod   = (2*WIDTH)'(abs_val(MAXW'({acc_hi, acc_lo}), neg_q));
    res_hi = !is_div ? prod[2*WIDTH-1:WIDTH] : WIDTH'(abs_val(MAXW'(dz ? acc_lo : acc_hi), neg_r));
    res_lo = !is_div ? prod[WIDTH-1:0] : dz ? '1 : WIDTH'(abs_val(MAXW'(acc_lo), neg_q));
  end
  always_ff @(posedge clk)
    if (reset) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= state == FIX || (accept && (op == MTHI || op == MTLO));
      if (accept) div_zero <= 1'b0;
      if (accept && op == MTHI) hi <= a;
      if (accept && op == MTLO) lo <= a;
      if (state == FIX) begin
        hi       <= res_hi;
        lo       <= res_lo;
        div_zero <= dz;
      end
    end
endmodule
